// File: rtl/sd_cmd_sender.sv
// ---------------------------------------------------------------------------
// sd_cmd_sender
//
// SPI-mode SD command engine. Accepts one command (index, argument, response
// type) from the SD controller FSM. Frames it as a 48-bit SD command
// {0,1,index,argument,crc7,1} and shifts it out MSB first on sck/mosi under
// cs (SPI mode 0). It then hunts for the R1 start bit on miso, captures an
// 8/16/40-bit response and reports it, or reports a timeout.
//
// Parameters
//   CLK_DIV        : system clock cycles per sck half-period (>= 1)
//   MAX_WAIT_BYTES : response-wait budget in bytes (8*MAX_WAIT_BYTES samples)
//
// Ports
//   i_clk          : system clock, all logic on the rising edge
//   i_rst_n        : asynchronous active-low reset
//   i_cmd_valid    : command request, accepted when valid && ready
//   i_cmd_index    : SD command index
//   i_cmd_argument : 32-bit command argument
//   i_resp_type    : response length 0->8, 1->16, 2->40, 3->8 bits
//   o_cmd_ready    : high only while idle
//   o_resp_valid   : one-cycle pulse when a response or timeout is reported
//   o_response     : captured response, right-aligned, held until next accept
//   o_timeout      : qualifies o_resp_valid, held with o_response
//   o_sck          : SPI clock, idle low
//   o_cs           : chip select, active low
//   o_mosi         : SPI data to card, idle high
//   i_miso         : SPI data from card
//
// Configuration macro
//   SD_CMD_CRC_EN  : when defined, CRC7 is computed from the latched index and
//                    argument. When undefined, the CRC7 field is a constant
//                    (CMD0 -> 7'h4A, CMD8 -> 7'h43, otherwise 7'h7F) and no
//                    CRC generator is built.
// ---------------------------------------------------------------------------
module sd_cmd_sender #(
  parameter int CLK_DIV        = 2,
  parameter int MAX_WAIT_BYTES = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  input  logic [5:0]  i_cmd_index,
  input  logic [31:0] i_cmd_argument,
  input  logic [1:0]  i_resp_type,
  output logic        o_cmd_ready,
  output logic        o_resp_valid,
  output logic [39:0] o_response,
  output logic        o_timeout,
  output logic        o_sck,
  output logic        o_cs,
  output logic        o_mosi,
  input  logic        i_miso
);

  localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WAIT_BITS = 8 * MAX_WAIT_BYTES;
  localparam int WAIT_W    = $clog2(WAIT_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_RECV,
    S_FINISH
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DIV_W-1:0]  r_div_cnt;
  logic              r_sck;
  logic              r_cs;
  logic              r_mosi;
  logic              r_resp_valid;
  logic              r_timeout;
  logic [5:0]        r_index;
  logic [31:0]       r_arg;
  logic [5:0]        r_bit_idx;
  logic [5:0]        r_len;
  logic [5:0]        r_rcv_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [39:0]       r_shift;
  logic [39:0]       r_response;

  logic [6:0]        w_crc;
  logic [47:0]       w_frame;
  logic [5:0]        w_bit_idx_dec;
  logic              w_accept;
  logic              w_active;
  logic              w_half_end;
  logic              w_rise;
  logic              w_fall;

  function automatic logic [5:0] f_resp_len(input logic [1:0] rt);
    logic [5:0] len;
    case (rt)
      2'd1:    len = 6'd16;
      2'd2:    len = 6'd40;
      default: len = 6'd8;
    endcase
    return len;
  endfunction

`ifdef SD_CMD_CRC_EN
  // CRC7, polynomial x^7 + x^3 + 1, init 0, MSB first over the 40-bit prefix.
  function automatic logic [6:0] f_crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) begin
        c = c ^ 7'h09;
      end
    end
    return c;
  endfunction

  assign w_crc = f_crc7({2'b01, r_index, r_arg});
`else
  // Only the commands that are sent before CRC checking is disabled on the
  // card need a real CRC; every other command carries an all-ones CRC field.
  always_comb begin
    w_crc = 7'h7F;
    case (r_index)
      6'd0:    w_crc = 7'h4A;
      6'd8:    w_crc = 7'h43;
      default: w_crc = 7'h7F;
    endcase
  end
`endif

  assign w_frame       = {2'b01, r_index, r_arg, w_crc, 1'b1};
  assign w_bit_idx_dec = r_bit_idx - 6'd1;

  assign w_accept   = i_cmd_valid && (r_state == S_IDLE);
  assign w_active   = (r_state == S_SEND) || (r_state == S_WAIT) ||
                      (r_state == S_RECV);
  assign w_half_end = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  // Rise: end of a low half-period (miso sample point). Fall: end of a bit.
  assign w_rise     = w_active && w_half_end && !r_sck;
  assign w_fall     = w_active && w_half_end && r_sck;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (w_fall && (r_bit_idx == 6'd0)) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // A 0 sample is the response MSB; otherwise give up once the budget
        // of samples has been spent and the last bit period has completed.
        if (w_rise && !i_miso) begin
          w_state_next = S_RECV;
        end else if (w_fall && (r_wait_cnt == WAIT_W'(WAIT_BITS))) begin
          w_state_next = S_FINISH;
        end
      end
      S_RECV: begin
        if (w_fall && (r_rcv_cnt == r_len)) begin
          w_state_next = S_FINISH;
        end
      end
      S_FINISH: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: sck divider, frame shifter, response capture and outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt    <= '0;
      r_sck        <= 1'b0;
      r_cs         <= 1'b1;
      r_mosi       <= 1'b1;
      r_resp_valid <= 1'b0;
      r_timeout    <= 1'b0;
      r_index      <= '0;
      r_arg        <= '0;
      r_bit_idx    <= '0;
      r_len        <= '0;
      r_rcv_cnt    <= '0;
      r_wait_cnt   <= '0;
      r_shift      <= '0;
      r_response   <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_index    <= i_cmd_index;
            r_arg      <= i_cmd_argument;
            r_len      <= f_resp_len(i_resp_type);
            r_cs       <= 1'b0;
            r_sck      <= 1'b0;
            // Bit 47 is the start bit, always 0.
            r_mosi     <= 1'b0;
            r_div_cnt  <= '0;
            r_bit_idx  <= 6'd47;
            r_wait_cnt <= '0;
            r_rcv_cnt  <= '0;
            r_shift    <= '0;
            r_response <= '0;
            r_timeout  <= 1'b0;
          end
        end
        S_SEND, S_WAIT, S_RECV: begin
          if (w_half_end) begin
            r_div_cnt <= '0;
            r_sck     <= ~r_sck;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end

          // mosi only moves while sck goes low, so it is stable at each rise.
          if ((r_state == S_SEND) && w_fall) begin
            if (r_bit_idx == 6'd0) begin
              r_mosi <= 1'b1;
            end else begin
              r_bit_idx <= w_bit_idx_dec;
              r_mosi    <= w_frame[w_bit_idx_dec];
            end
          end

          if ((r_state == S_WAIT) && w_rise) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
            if (!i_miso) begin
              r_shift   <= {r_shift[38:0], 1'b0};
              r_rcv_cnt <= 6'd1;
            end
          end

          if ((r_state == S_RECV) && w_rise) begin
            r_shift   <= {r_shift[38:0], i_miso};
            r_rcv_cnt <= r_rcv_cnt + 6'd1;
          end

          if (w_state_next == S_FINISH) begin
            r_sck        <= 1'b0;
            r_cs         <= 1'b1;
            r_mosi       <= 1'b1;
            r_resp_valid <= 1'b1;
            if (r_state == S_WAIT) begin
              r_response <= 40'hFF_FFFF_FFFF;
              r_timeout  <= 1'b1;
            end else begin
              // The shifter was cleared on accept, so the upper bits are zero.
              r_response <= r_shift;
              r_timeout  <= 1'b0;
            end
          end
        end
        default: begin
          r_sck <= 1'b0;
          r_cs  <= 1'b1;
        end
      endcase
    end
  end

  assign o_cmd_ready  = (r_state == S_IDLE);
  assign o_resp_valid = r_resp_valid;
  assign o_response   = r_response;
  assign o_timeout    = r_timeout;
  assign o_sck        = r_sck;
  assign o_cs         = r_cs;
  assign o_mosi       = r_mosi;

endmodule

// File: tb/tb_sd_cmd_sender.sv
module tb_sd_cmd_sender;

  localparam int CD  = 2;
  localparam int MWB = 8;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_argument;
  logic [1:0]  resp_type;
  logic        cmd_ready;
  logic        resp_valid;
  logic [39:0] response;
  logic        timeout;
  logic        sck;
  logic        cs;
  logic        mosi;
  logic        miso;

  sd_cmd_sender #(.CLK_DIV(CD), .MAX_WAIT_BYTES(MWB)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_cmd_valid    (cmd_valid),
    .i_cmd_index    (cmd_index),
    .i_cmd_argument (cmd_argument),
    .i_resp_type    (resp_type),
    .o_cmd_ready    (cmd_ready),
    .o_resp_valid   (resp_valid),
    .o_response     (response),
    .o_timeout      (timeout),
    .o_sck          (sck),
    .o_cs           (cs),
    .o_mosi         (mosi),
    .i_miso         (miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Card model: counts sck rises under cs, records the first 48 mosi bits,
  // and presents its response after card_delay idle (1) bit periods.
  int          rise_cnt   = 0;
  int          rises_done = 0;
  logic [47:0] cap_frame  = '0;
  logic [39:0] card_resp  = '0;
  int          card_len   = 8;
  int          card_delay = 1000;

  always @(posedge sck or posedge cs) begin
    if (cs) begin
      rises_done = rise_cnt;
      rise_cnt   = 0;
    end else begin
      if (rise_cnt < 48) cap_frame = {cap_frame[46:0], mosi};
      rise_cnt = rise_cnt + 1;
    end
  end

  always_comb begin
    int p;
    p    = rise_cnt - 47;
    miso = 1'b1;
    if (p > card_delay && p <= card_delay + card_len)
      miso = card_resp[card_len - (p - card_delay)];
  end

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [1:0]  rt;
    logic [39:0] card;
    int          clen;
    int          delay;
    logic [47:0] frame;
    logic [39:0] resp;
    logic        to;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [6:0] bench_crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] bench_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [6:0] c;
`ifdef SD_CMD_CRC_EN
    c = bench_crc7({2'b01, idx, arg});
`else
    c = (idx == 6'd0) ? 7'h4A : (idx == 6'd8) ? 7'h43 : 7'h7F;
`endif
    return {2'b01, idx, arg, c, 1'b1};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one command and check frame, latency, response, wait length and
  // the quiet period afterwards. With poke set, a different command is
  // presented on cmd_valid during the command phase.
  task automatic run_cmd(input vec_t v, input string tag, input bit poke);
    int lat;
    int exp_lat;
    int exp_rises;
    int extra;
    int len;
    len       = (v.rt == 2'd1) ? 16 : (v.rt == 2'd2) ? 40 : 8;
    exp_rises = v.to ? 8 * MWB : v.delay + len;
    exp_lat   = 96 * CD + 2 * CD * exp_rises + 1;
    card_resp  = v.card;
    card_len   = v.clen;
    card_delay = v.delay;
    @(negedge clk);
    chk({tag, ".ready_idle"}, cmd_ready, 1'b1);
    cmd_valid    = 1'b1;
    cmd_index    = v.idx;
    cmd_argument = v.arg;
    resp_type    = v.rt;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    chk({tag, ".accept_edge"}, {cs, sck, mosi, cmd_ready}, 4'b0000);
    while (!resp_valid && lat < 3000) begin
      if (poke && lat == 10) begin
        cmd_valid    = 1'b1;
        cmd_index    = 6'd8;
        cmd_argument = 32'h1AA;
        resp_type    = 2'd2;
      end
      if (poke && lat == 20) chk({tag, ".busy_ready"}, cmd_ready, 1'b0);
      if (poke && lat == 30) cmd_valid = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".frame"}, cap_frame, v.frame);
    chk({tag, ".response"}, response, v.resp);
    chk({tag, ".timeout"}, timeout, v.to);
    chk({tag, ".cs_at_valid"}, {cs, sck}, 2'b10);
    @(negedge clk);
    chk({tag, ".wait_rises"}, rises_done - 48, exp_rises);
    chk({tag, ".pulse_width"}, {resp_valid, cmd_ready}, 2'b01);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid || !cs) extra++;
      @(negedge clk);
    end
    chk({tag, ".quiet_after"}, extra, 0);
    chk({tag, ".response_held"}, {timeout, response}, {v.to, v.resp});
  endtask

  initial begin
    int seen;
    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_index    = '0;
    cmd_argument = '0;
    resp_type    = '0;

    vecs[0] = '{6'd0,  32'h0,      2'd0, 40'h01,           8,  2,    48'h40_0000_0000_95, 40'h01,           1'b0};
    vecs[1] = '{6'd8,  32'h1AA,    2'd2, 40'h01_0000_01AA, 40, 1,    48'h48_0000_01AA_87, 40'h01_0000_01AA, 1'b0};
    vecs[2] = '{6'd17, 32'h1000,   2'd0, 40'h00,           8,  3,    bench_frame(6'd17, 32'h1000), 40'h0, 1'b0};
    vecs[3] = '{6'd13, 32'h0,      2'd1, 40'h0105,         16, 0,    bench_frame(6'd13, 32'h0),    40'h0105, 1'b0};
    vecs[4] = '{6'd58, 32'h0,      2'd3, 40'h05,           8,  5,    bench_frame(6'd58, 32'h0),    40'h05,   1'b0};
    vecs[5] = '{6'd1,  32'h4000_0000, 2'd0, 40'h00,        8,  1000, bench_frame(6'd1, 32'h4000_0000), 40'hFF_FFFF_FFFF, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset.outputs", {cs, sck, mosi, cmd_ready, resp_valid, timeout}, 6'b101100);
    chk("reset.response", response, 40'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_cmd(vecs[i], $sformatf("vec%0d", i), 1'b0);

    // Reset in the middle of the command phase.
    card_resp  = 40'h01;
    card_len   = 8;
    card_delay = 2;
    @(negedge clk);
    cmd_valid    = 1'b1;
    cmd_index    = 6'd0;
    cmd_argument = 32'h0;
    resp_type    = 2'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    seen = 0;
    while (rise_cnt < 20 && seen < 500) begin
      @(negedge clk);
      seen++;
    end
    chk("midreset.reached_bit20", rise_cnt, 20);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset.outputs", {cs, sck, mosi, cmd_ready, resp_valid}, 5'b10110);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (resp_valid || !cs) seen++;
      @(negedge clk);
    end
    chk("midreset.no_pulse", seen, 0);
    run_cmd(vecs[0], "after_reset", 1'b0);

    // Different command presented while busy must be ignored.
    run_cmd(vecs[0], "busy", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_cmd_sender.md
# sd_cmd_sender

- SPI-mode SD command engine in the memory/SD path: accepts one command (index, argument, expected response type) from the SD controller FSM.
- Frames it as a 48-bit SD command with CRC7 and shifts it out on sck/mosi under cs.
- Hunts for the R1 start bit on miso, captures an 8/16/40-bit response and reports it, or times out.
- Sits directly upstream of the SD card (or its bench model), driving its sck/cs/mosi and consuming miso.

## Interface
- CLK_DIV, 2: clock cycles per sck half-period; legal range ≥1.
- MAX_WAIT_BYTES, 8: response-wait budget in bytes; budget = 8*MAX_WAIT_BYTES sampled bits.
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request; accepted when cmd_valid && cmd_ready.
- cmd_index  in  6  SD command index.
- cmd_argument  in  32  command argument.
- resp_type  in  2  response length: 0→8 bits, 1→16 bits, 2→40 bits, 3→8 bits.
- cmd_ready  out  1  high only in Idle.
- resp_valid  out  1  one-cycle pulse when response or timeout is reported.
- response  out  40  captured response, right-aligned, upper bits zero; held until next accept.
- timeout  out  1  qualifies resp_valid; held with response.
- sck  out  1  SPI clock, mode 0, idle low.
- cs  out  1  chip select, active low.
- mosi  out  1  SPI data to card; idle high.
- miso  in  1  SPI data from card.

## Operation
- Reset values:
  - Outputs: cs=1, sck=0, mosi=1, cmd_ready=1, resp_valid=0, response=0, timeout=0.
  - Internal: state=Idle, counters=0.
- Idle
  - On accept, latch inputs.
  - Build frame {0,1,cmd_index,cmd_argument,crc7,1}.
  - CRC7 is polynomial x^7+x^3+1, init 0, MSB-first over the 40-bit prefix.
  - Go to SendCmd.
- SendCmd
  - cs=0; 48 bits MSB first.
  - Each bit: CLK_DIV cycles sck low, then CLK_DIV cycles sck high.
  - mosi changes only while sck is low (at falling transition or entry).
  - After bit 0's high phase, go to WaitResp.
- WaitResp
  - mosi=1; sck keeps toggling.
  - miso is sampled on the cycle sck goes high.
  - First sampled 0 is response bit [len-1]; go to RecvResp.
  - If 8*MAX_WAIT_BYTES samples are all 1: response=40'hFF_FFFF_FFFF, timeout=1, go to Finish.
- RecvResp
  - Shift in the remaining len-1 bits, MSB first, on sck rising.
  - Then timeout=0, response right-aligned, go to Finish.
- Finish
  - sck=0, cs=1, resp_valid=1 for exactly one cycle.
  - Go to Idle.
- Busy behaviour: cmd_valid outside Idle is ignored; the inputs are not re-latched.
- Reset mid-operation: all outputs return to reset values asynchronously, with no partial response pulse.

## Timing
- Accept edge: cs falls and mosi=bit47 on the next clock; sck is still low.
- Command phase: exactly 96*CLK_DIV cycles.
- Card latency: a response whose start bit arrives at sampled position k (1-based) in WaitResp costs (k + len - 1)*2*CLK_DIV cycles after the command phase, plus 1 Finish cycle.
- Back-to-back: the next command may be accepted the cycle after resp_valid (cmd_ready=1 in Idle).
- Timeout: resp_valid is asserted at most 96*CLK_DIV + 16*MAX_WAIT_BYTES*CLK_DIV + 1 cycles after accept.
- Frame edge cases: cs never rises between the command and the response; sck never glitches shorter than CLK_DIV.

## Configuration
- Macro: SD_CMD_CRC_EN.
- Defined: CRC7 is computed combinationally from the latched index and argument for every command.
- Undefined: CRC7 field is a constant.
  - index 0 → 7'h4A.
  - index 8 → 7'h43 (valid only for argument 32'h1AA).
  - any other index → 7'h7F.
  - The CRC generator is removed.

## Test plan
- CMD0, argument 0, resp_type 0:
  - mosi frame must be 48'h40_0000_0000_95.
  - Card answers 8'h01 after 2 idle bits: response=40'h01, timeout=0, one resp_valid pulse.
- CMD8, argument 32'h1AA, resp_type 2:
  - Frame must be 48'h48_0000_01AA_87.
  - Card returns 40'h01_0000_01AA: response=40'h01_0000_01AA.
- CMD17, argument 32'h0000_1000, SD_CMD_CRC_EN defined: frame CRC7 must equal the bench CRC7 of {2'b01,6'o21,32'h1000}; card 8'h00 → response=0.
- miso held 1, MAX_WAIT_BYTES=8:
  - Exactly 64 sck rising edges in WaitResp.
  - Then resp_valid with timeout=1 and response=40'hFF_FFFF_FFFF; cs high after.
- Reset pulsed after 20 command bits:
  - cs=1, sck=0, mosi=1, cmd_ready=1 immediately; no resp_valid.
  - A following CMD0 completes correctly.
- cmd_valid toggled with a different index during SendCmd: cmd_ready=0, frame unchanged, single response for the original command.
